// File: rtl/maze_pkg.sv
// Shared types and constants for the maze RAM and its requester arbiter.
package maze_pkg;

   localparam int MAZE_AW = 4;

   localparam logic WALL = 1'b1;
   localparam logic FREE = 1'b0;

   typedef enum logic {ARB, LOCK} arb_state_t;
   typedef enum logic {OWN_RAT, OWN_HOST} owner_t;

endpackage

// File: rtl/rr_lock_fsm.sv
// Round-robin grant FSM with a host burst lock; a starvation counter
// forces one rat slot after LOCK_MAX consecutive host grants.
module rr_lock_fsm
   import maze_pkg::*;
#(
   parameter int LOCK_MAX = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic req0,
   input  logic req1,
   input  logic lock,
   output logic gnt0,
   output logic gnt1,
   output logic locked
);

   localparam logic [7:0] STARVE_MAX = 8'(LOCK_MAX);

   arb_state_t state, state_next;
   logic       ptr, ptr_next;
   logic [7:0] starve_cnt, starve_next;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ARB;
         ptr        <= 1'b0;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         starve_cnt <= starve_next;
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next  = state;
      ptr_next    = ptr;
      starve_next = starve_cnt;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      case (state)
         ARB: begin
            if (req0 && (!req1 || !ptr)) begin
               gnt0     = 1'b1;
               ptr_next = 1'b1;
            end else if (req1) begin
               gnt1     = 1'b1;
               ptr_next = 1'b0;
               if (lock) state_next = LOCK;
            end
         end
         LOCK: begin
            // Increment only below the limit, so the counter saturates at LOCK_MAX.
            if (req1 && (!req0 || starve_cnt < STARVE_MAX)) begin
               gnt1        = 1'b1;
               starve_next = req0 ? starve_cnt + 8'd1 : 8'd0;
            end else begin
               gnt0        = req0;
               starve_next = 8'd0;
            end
            if (!lock) begin
               state_next  = ARB;
               ptr_next    = 1'b0;
               starve_next = 8'd0;
            end
         end
         default: state_next = ARB;
      endcase
      // Grants are suppressed while reset is held so no RAM access leaks out.
      if (!RST) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign locked = (state == LOCK);

endmodule

// File: rtl/maze_mem_arbiter.sv
// Two-port arbiter in front of the single-ported maze RAM: rat (r0) and host (r1),
// with combinational grant/address muxing and a one-cycle read-return path.
module maze_mem_arbiter
   import maze_pkg::*;
#(
   parameter int AW       = MAZE_AW,
   parameter int LOCK_MAX = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_x,
   input  logic [AW-1:0] r0_y,
   input  logic          r0_wd,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic          r0_rd,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_x,
   input  logic [AW-1:0] r1_y,
   input  logic          r1_wd,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic          r1_rd,
   input  logic          r1_lock,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_x,
   output logic [AW-1:0] mem_y,
   output logic          mem_din,
   input  logic          mem_dout,
   output logic          locked
);

   logic   rd_valid;
   owner_t rd_owner;

   rr_lock_fsm #(.LOCK_MAX(LOCK_MAX)) u_fsm (
      .CLK    (CLK),
      .RST    (RST),
      .req0   (r0_req),
      .req1   (r1_req),
      .lock   (r1_lock),
      .gnt0   (r0_gnt),
      .gnt1   (r1_gnt),
      .locked (locked)
   );

   always_comb begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      mem_x   = '0;
      mem_y   = '0;
      mem_din = FREE;
      if (r0_gnt) begin
         mem_rd  = ~r0_we;
         mem_wr  = r0_we;
         mem_x   = r0_x;
         mem_y   = r0_y;
         mem_din = r0_wd;
      end else if (r1_gnt) begin
         mem_rd  = ~r1_we;
         mem_wr  = r1_we;
         mem_x   = r1_x;
         mem_y   = r1_y;
         mem_din = r1_wd;
      end
   end

   // The owner tag follows each read strobe so alternating readers return in order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_valid <= 1'b0;
         rd_owner <= OWN_RAT;
      end else begin
         rd_valid <= mem_rd;
         if (mem_rd) rd_owner <= r1_gnt ? OWN_HOST : OWN_RAT;
      end
   end

   assign r0_rvalid = rd_valid && (rd_owner == OWN_RAT);
   assign r1_rvalid = rd_valid && (rd_owner == OWN_HOST);
   assign r0_rd     = r0_rvalid ? mem_dout : FREE;
   assign r1_rd     = r1_rvalid ? mem_dout : FREE;

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
- Shares the single 16x16 one-bit maze RAM between two requesters.
- Requester 0 is the rat controller/datapath, which walks the maze. Requester 1 is the host maze-loader/debug port, which writes walls and reads back the path.
- Round-robin arbitration, one memory access per cycle, sync-RAM read latency of 1.
- Host may lock the RAM for burst loading; a starvation limit guarantees the rat still gets a slot.

Parameters:
- AW, 4, width of each X/Y coordinate (maze is 2^AW x 2^AW).
- LOCK_MAX, 16, max consecutive locked host grants while r0 is waiting; range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- r0_req  in  1  rat access request, held until granted.
- r0_we  in  1  1 = write, 0 = read.
- r0_x, r0_y  in  AW each  cell coordinate.
- r0_wd  in  1  write data (1 = wall/visited).
- r0_gnt  out  1  access performed this cycle.
- r0_rvalid  out  1  read data valid; one cycle after a granted read.
- r0_rd  out  1  read data.
- r1_req, r1_we, r1_x, r1_y, r1_wd, r1_gnt, r1_rvalid, r1_rd: same as r0_*, for the host.
- r1_lock  in  1  host requests exclusive burst access.
- mem_rd  out  1  RAM read strobe.
- mem_wr  out  1  RAM write strobe.
- mem_x, mem_y  out  AW each  RAM address.
- mem_din  out  1  RAM write data.
- mem_dout  in  1  RAM read data, valid the cycle after mem_rd.
- locked  out  1  FSM is in LOCK.

Behaviour:
- Reset (RST=0, async):
  - state=ARB, ptr=0 (r0 favoured first), starve_cnt=0.
  - r0_rvalid=r1_rvalid=0, last_rd_owner cleared.
  - All gnt and mem strobes are 0 because they are combinational from the reset-cleared regs; locked=0.
- Grant is combinational within the cycle:
  - At most one gnt is high.
  - gnt is never high without the matching req.
  - The granted requester's we/x/y/wd drive mem_*.
  - mem_rd = gnt & ~we; mem_wr = gnt & we.
  - No grant → mem_rd=mem_wr=0, mem_x/mem_y/mem_din=0.
- ARB state:
  - Only one req high → grant it.
  - Both high → grant the one ptr favours.
  - On any grant, ptr points to the other requester.
  - r1 granted with r1_lock=1 → next state LOCK.
- LOCK state:
  - r1_req=1 and (r0_req=0 or starve_cnt<LOCK_MAX) → grant r1. starve_cnt increments if r0_req, else clears.
  - r0_req=1 and starve_cnt==LOCK_MAX → grant r0 for exactly that cycle, clear starve_cnt, stay LOCK.
  - r1_req=0 → r0 granted if requesting; starve_cnt clears.
  - Exit to ARB on the edge where r1_lock=0 is sampled. A grant made in that cycle still follows LOCK rules. After exit, ptr=0.
  - starve_cnt saturates at LOCK_MAX and is 8 bits wide.
- Read return:
  - A registered owner tag records which requester issued mem_rd.
  - Next cycle: that requester's rvalid=1 and rd=mem_dout. The other requester's rvalid=0 and rd=0.
  - Back-to-back reads to alternating requesters are supported; each returns in order, latency exactly 1.
- Writes have no response; gnt is the completion.
- Simultaneous events:
  - r1_lock rising while r0 is granted (ptr case): LOCK is entered only on a cycle when r1 is granted.
  - Write and read to the same cell in consecutive cycles: read returns the new value (RAM write-first is the RAM's contract; arbiter preserves order).
- Reset mid-operation: a pending rvalid is dropped and the lock is released. Requesters must re-issue.

Decomposition:
- Shared package maze_pkg:
  - coordinate width constant MAZE_AW=4.
  - typedef arb_state_t {ARB, LOCK}.
  - typedef owner_t {OWN_RAT, OWN_HOST}.
  - Cell encoding constants WALL=1, FREE=0.
- One sub-module: rr_lock_fsm. It owns state, ptr and starve_cnt, and outputs the grant vector. The top holds the muxes and the read-return register.

Test Plan:
- Reset then r0 read at (3,5), RAM holds 1 → r0_gnt same cycle, mem_rd=1, mem_x=3, mem_y=5; next cycle r0_rvalid=1, r0_rd=1, r1_rvalid=0.
- Both requesters continuously request reads for 6 cycles → grants alternate r0,r1,r0,r1,r0,r1; rvalid alternates one cycle delayed.
- r1 writes 1 to (15,15) with lock held; r0_req held; LOCK_MAX=4 → r1 granted 4 cycles, then r0 once, then r1 again; locked=1 throughout.
- r1_lock drops with both requesting → that cycle r1 granted, next cycle state ARB and r0 granted (ptr=0).
- Write (2,2)=1 by r0, then r1 read (2,2) the next cycle → r1_rd=1 one cycle after its grant.
- RST asserted the cycle after a granted r1 read, in LOCK → immediately r1_rvalid=0, locked=0, no mem strobes. After release, r0 wins the first contested cycle.
